pkt_deframer: RTL and testbench
===============================

PKT_DEFRAMER -- requirements
Module: pkt_deframer

Interface
REQ-001 Parameter CLOCK, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600: link baud rate, used only to derive the timeout.
REQ-003 Parameter MAX_LEN, default 16: maximum payload bytes per packet.
REQ-004 Parameter TO_BYTES, default 4: inter-byte timeout, in byte times.
REQ-005 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port data_in, input, 8: received byte, valid only when data_ready=1.
REQ-008 Port data_ready, input, 1: one-cycle strobe from the UART receiver.
REQ-009 Port pkt_valid, output, 1: a checked packet is held in the buffer.
REQ-010 Port pkt_len, output, $clog2(MAX_LEN+1): payload length of the held packet.
REQ-011 Port rd_addr, input, $clog2(MAX_LEN): payload read index.
REQ-012 Port rd_data, output, 8: buffer[rd_addr], combinational read.
REQ-013 Port pkt_ack, input, 1: consumer releases the held packet.
REQ-014 Port err_chk, err_len, err_to, overrun, output, 1 each: one-cycle error pulses.

Function
REQ-015 Frame format SHALL be SYNC(0xA5), LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-016 FSM states SHALL be HUNT, LEN, PAYLOAD, CHECK and HOLD; the FSM SHALL advance only on a data_ready strobe, except for timeout and ack.
REQ-017 HUNT: data_in==0xA5 -> LEN; any other byte is discarded with no flag.
REQ-018 LEN: a value of 0 or greater than MAX_LEN -> pulse err_len, go to HUNT; otherwise latch the length, seed the running XOR with LEN, clear the byte index, go to PAYLOAD.
REQ-019 PAYLOAD: write the byte to buffer[index], XOR it into the running XOR, and increment the index; when index reaches LEN -> CHECK.
REQ-020 Byte 0xA5 inside LEN/PAYLOAD/CHECK SHALL be treated as data (no escaping, no resync).
REQ-021 CHECK: data_in == running XOR -> HOLD, with pkt_valid=1 on the next cycle; mismatch -> pulse err_chk, go to HUNT, pkt_valid stays 0.
REQ-022 HOLD: pkt_valid=1, and pkt_len and the buffer SHALL be stable until pkt_ack.
REQ-023 HOLD with pkt_ack=1 -> HUNT, pkt_valid=0 on the next cycle.
REQ-024 HOLD, pkt_ack=1 and data_ready with 0xA5 in the same cycle -> LEN (the ack is honoured and the sync is accepted).
REQ-025 HOLD, pkt_ack=0 and data_ready with 0xA5 -> pulse overrun; every byte in HOLD is dropped.
REQ-026 Timeout: TO_CYC = TO_BYTES*10*(CLOCK/BAUD) clocks (208320 at defaults).
REQ-027 The timeout counter SHALL run only in LEN, PAYLOAD and CHECK, and SHALL clear on every data_ready and on entry from HUNT.
REQ-028 Counter reaching TO_CYC-1 with no data_ready -> pulse err_to, go to HUNT.
REQ-029 data_ready in the timeout cycle SHALL take priority over the timeout.
REQ-030 pkt_ack outside HOLD SHALL be ignored.
REQ-031 rd_addr greater than or equal to pkt_len SHALL return stale buffer contents, without error.
REQ-032 Latency: pkt_valid SHALL rise exactly one cycle after the CHK byte strobe.
REQ-033 Error pulses SHALL be exactly one cycle wide and registered.

Reset
REQ-034 rst=0 SHALL asynchronously force state HUNT, with pkt_valid, pkt_len, every error pulse, the index, the running XOR and the timeout counter all 0.
REQ-035 Buffer contents need not be reset.
REQ-036 Reset mid-packet SHALL discard the partial packet with no error pulse.
REQ-037 Operation SHALL resume in the first cycle after rst deasserts.

Structure
REQ-038 A shared package pkt_pkg SHALL hold the state enum, SYNC_BYTE=8'hA5 and a function that computes TO_CYC.
REQ-039 One sub-module, pkt_buf (MAX_LEN x 8 register file, one write port, one combinational read port), SHALL be instantiated.
REQ-040 The counter-width derivation SHALL use $clog2 of TO_CYC.

Verification
REQ-041 Bytes A5 03 11 22 33 03 -> pkt_valid=1, pkt_len=3; rd_addr 0,1,2 returns 11,22,33; pkt_ack -> pkt_valid=0 on the next cycle.
REQ-042 Bytes A5 03 11 22 33 04 -> err_chk pulses once, pkt_valid stays 0; a following valid packet is accepted.
REQ-043 Bytes A5 00, then A5 11 (MAX_LEN=16) -> err_len pulses twice, state returns to HUNT.
REQ-044 Bytes A5 02 AA, then a silence of TO_CYC clocks -> err_to pulses once; A5 01 A5 A4 afterwards -> pkt_valid=1, rd_data[0]=A5.
REQ-045 Packet held, new A5 arrives without ack -> overrun pulses and the buffer is unchanged; ack in the same cycle as A5 -> the next packet is accepted.
REQ-046 rst=0 asserted after A5 03 11 -> all outputs 0 immediately; a full valid packet after release is accepted.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet deframer.
package pkt_pkg;

    // Receive FSM states.
    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_HOLD
    } state_t;

    // Start-of-frame marker.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Inter-byte timeout in clocks: to_bytes byte times of 10 bits each.
    function automatic int unsigned to_cycles(input int unsigned clock,
                                              input int unsigned baud,
                                              input int unsigned to_bytes);
        return to_bytes * 10 * (clock / baud);
    endfunction

endpackage

// File: rtl/pkt_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
module pkt_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Store one payload byte per write strobe; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pkt_deframer.sv
// Deframes SYNC/LEN/payload/CHK packets from a UART byte stream into a held buffer.
module pkt_deframer
    import pkt_pkg::*;
#(
    parameter int unsigned CLOCK    = 50000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned TO_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   data_in,
    input  logic                         data_ready,
    output logic                         pkt_valid,
    output logic [$clog2(MAX_LEN+1)-1:0] pkt_len,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
    output logic [7:0]                   rd_data,
    input  logic                         pkt_ack,
    output logic                         err_chk,
    output logic                         err_len,
    output logic                         err_to,
    output logic                         overrun
);

    localparam int unsigned LW     = $clog2(MAX_LEN + 1);
    localparam int unsigned AW     = $clog2(MAX_LEN);
    localparam int unsigned TO_CYC = to_cycles(CLOCK, BAUD, TO_BYTES);
    localparam int unsigned CW     = $clog2(TO_CYC);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

    state_t        state;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx;
    logic [7:0]    run_xor;
    logic [CW-1:0] to_cnt;
    logic          wr_en;

    // Payload bytes go straight into the buffer at the current index.
    always_comb begin
        wr_en = (state == ST_PAYLOAD) && data_ready;
    end

    pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (idx[AW-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Receive FSM, inter-byte timeout and registered status/error outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_HUNT;
            len_q     <= '0;
            idx       <= '0;
            run_xor   <= '0;
            to_cnt    <= '0;
            pkt_valid <= 1'b0;
            pkt_len   <= '0;
            err_chk   <= 1'b0;
            err_len   <= 1'b0;
            err_to    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            err_chk <= 1'b0;
            err_len <= 1'b0;
            err_to  <= 1'b0;
            overrun <= 1'b0;

            // Timeout only applies mid-frame; a strobe in the expiry cycle wins.
            if (state inside {ST_LEN, ST_PAYLOAD, ST_CHECK}) begin
                if (data_ready) begin
                    to_cnt <= '0;
                end else if (to_cnt == TO_LAST) begin
                    to_cnt <= '0;
                    err_to <= 1'b1;
                    state  <= ST_HUNT;
                end else begin
                    to_cnt <= to_cnt + CW'(1);
                end
            end else begin
                to_cnt <= '0;
            end

            case (state)
                ST_HUNT: begin
                    if (data_ready && data_in == SYNC_BYTE) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (data_ready) begin
                        if (data_in == 8'h00 || 32'(data_in) > MAX_LEN) begin
                            err_len <= 1'b1;
                            state   <= ST_HUNT;
                        end else begin
                            len_q   <= LW'(data_in);
                            run_xor <= data_in;
                            idx     <= '0;
                            state   <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (data_ready) begin
                        run_xor <= run_xor ^ data_in;
                        idx     <= idx + LW'(1);
                        if (idx + LW'(1) == len_q) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (data_ready) begin
                        if (data_in == run_xor) begin
                            pkt_valid <= 1'b1;
                            pkt_len   <= len_q;
                            state     <= ST_HOLD;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= ST_HUNT;
                        end
                    end
                end
                ST_HOLD: begin
                    // An ack coinciding with a sync byte releases and restarts in one step.
                    if (pkt_ack) begin
                        pkt_valid <= 1'b0;
                        if (data_ready && data_in == SYNC_BYTE) begin
                            state <= ST_LEN;
                        end else begin
                            state <= ST_HUNT;
                        end
                    end else if (data_ready && data_in == SYNC_BYTE) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_deframer.sv
// Randomized scoreboard bench for pkt_deframer with a frame-level reference model.
`timescale 1ns/100ps
module tb_pkt_deframer;

    localparam int unsigned CLOCK    = 2000;
    localparam int unsigned BAUD     = 100;
    localparam int unsigned MAX_LEN  = 16;
    localparam int unsigned TO_BYTES = 1;
    localparam int unsigned TO_CYC   = TO_BYTES * 10 * (CLOCK / BAUD);

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_ready;
    logic       pkt_valid;
    logic [4:0] pkt_len;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       pkt_ack;
    logic       err_chk, err_len, err_to, overrun;

    pkt_deframer #(
        .CLOCK    (CLOCK),
        .BAUD     (BAUD),
        .MAX_LEN  (MAX_LEN),
        .TO_BYTES (TO_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_ready (data_ready),
        .pkt_valid  (pkt_valid),
        .pkt_len    (pkt_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pkt_ack    (pkt_ack),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_to     (err_to),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef enum int {EV_VALID, EV_FALL, EV_CHK, EV_LEN, EV_TO, EV_OVR} ev_t;
    typedef struct {
        ev_t          kind;
        int unsigned  at;
        int unsigned  len;
        logic [127:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        held;
    int unsigned edge_at = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input ev_t k, input int unsigned at,
                                 input int unsigned len, input logic [127:0] d);
        exp_t e;
        e.kind = k;
        e.at   = at;
        e.len  = len;
        e.data = d;
        sbq.push_back(e);
    endfunction

    task automatic read_buf(input exp_t e);
        for (int i = 0; i < int'(e.len); i++) begin
            rd_addr = 4'(i);
            #0.2;
            check("rd_data", 128'(rd_data), 128'(e.data[i*8 +: 8]));
        end
    endtask

    task automatic mon_event(input ev_t k);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d, want none", k.name(), cyc);
            return;
        end
        e = sbq.pop_front();
        check("event_kind", 128'(k), 128'(e.kind));
        check("event_cycle", 128'(cyc), 128'(e.at));
        if (k == EV_VALID && e.kind == EV_VALID) begin
            check("pkt_len", 128'(pkt_len), 128'(e.len));
            held = e;
            read_buf(e);
        end
        if (k == EV_OVR && e.kind == EV_OVR) begin
            check("ovr_valid_held", 128'(pkt_valid), 128'(1));
            check("ovr_len_held", 128'(pkt_len), 128'(held.len));
            read_buf(held);
        end
    endtask

    // Monitor: turn output activity into events and check them against the scoreboard.
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_v = 1'b0;
                continue;
            end
            if (pkt_valid && !prev_v) mon_event(EV_VALID);
            if (!pkt_valid && prev_v) mon_event(EV_FALL);
            if (err_chk) mon_event(EV_CHK);
            if (err_len) mon_event(EV_LEN);
            if (err_to)  mon_event(EV_TO);
            if (overrun) mon_event(EV_OVR);
            prev_v = pkt_valid;
        end
    end

    // Stimulus helpers: each drive occupies one clock; edge_at is the edge that samples it.
    task automatic drive(input logic dr, input logic [7:0] d, input logic ack);
        @(negedge clk);
        data_ready = dr;
        data_in    = d;
        pkt_ack    = ack;
        edge_at    = cyc + 1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) drive(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic send(input logic [7:0] b, input int unsigned gap);
        repeat (gap - 1) drive(1'b0, 8'($urandom), 1'b0);
        drive(1'b1, b, 1'b0);
    endtask

    function automatic int unsigned rgap(input int mode);
        int unsigned r;
        if (mode == 0) return 1;
        if (mode == 2) return TO_CYC;
        r = $urandom_range(0, 39);
        if (r == 0) return TO_CYC;
        if (r == 1) return TO_CYC - 1;
        return $urandom_range(1, 3);
    endfunction

    function automatic logic [7:0] non_sync();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        return b;
    endfunction

    function automatic logic [127:0] rand_payload();
        logic [127:0] p;
        for (int i = 0; i < 16; i++) begin
            p[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
        end
        return p;
    endfunction

    // Full frame; a nonzero delta corrupts the check byte.
    task automatic frame_ok(input int unsigned len, input logic [127:0] pl,
                            input logic [7:0] delta, input bit skip_sync, input int gmode);
        logic [7:0] x;
        if (!skip_sync) send(8'hA5, $urandom_range(1, 3));
        send(8'(len), rgap(gmode));
        x = 8'(len);
        for (int i = 0; i < int'(len); i++) begin
            send(pl[i*8 +: 8], rgap(gmode));
            x = x ^ pl[i*8 +: 8];
        end
        send(x ^ delta, rgap(gmode));
        if (delta == 8'h00) push(EV_VALID, edge_at, len, pl);
        else                push(EV_CHK, edge_at, 0, '0);
    endtask

    task automatic frame_badlen(input logic [7:0] v, input bit skip_sync);
        if (!skip_sync) send(8'hA5, 1);
        send(v, rgap(1));
        push(EV_LEN, edge_at, 0, '0);
    endtask

    // Frame cut short after 'cut' bytes following the sync, then left silent.
    task automatic frame_timeout(input int unsigned len, input logic [127:0] pl,
                                 input int unsigned cut, input bit skip_sync);
        if (!skip_sync) send(8'hA5, 1);
        for (int k = 0; k < int'(cut); k++) begin
            send((k == 0) ? 8'(len) : pl[(k-1)*8 +: 8], rgap(1));
        end
        push(EV_TO, edge_at + TO_CYC, 0, '0);
        idle(TO_CYC + 4);
    endtask

    // mode 0: ack; 1: overrun then ack; 2: overrun then ack with sync; 3: random.
    task automatic hold_phase(input int mode, output bit skip);
        int n;
        int m;
        bit long_wait;
        m = (mode == 3) ? $urandom_range(0, 2) : mode;
        long_wait = (mode == 3) && ($urandom_range(0, 4) == 0);
        skip = 1'b0;
        n = 0;
        while (!pkt_valid && n < 4) begin
            idle(1);
            n++;
        end
        checks++;
        if (!pkt_valid) begin
            errors++;
            $display("FAIL valid_wait: got pkt_valid=0 want 1 (cycle %0d)", cyc);
            return;
        end
        if (long_wait) idle(TO_CYC + 5);
        if (m >= 1) begin
            repeat ($urandom_range(0, 2)) send(non_sync(), 1);
            send(8'hA5, 1);
            push(EV_OVR, edge_at, 0, '0);
        end
        if (m == 2) begin
            drive(1'b1, 8'hA5, 1'b1);
            push(EV_FALL, edge_at, 0, '0);
            skip = 1'b1;
        end else begin
            drive(1'b0, 8'($urandom), 1'b1);
            push(EV_FALL, edge_at, 0, '0);
        end
    endtask

    task automatic reset_now();
        @(negedge clk);
        data_ready = 1'b0;
        pkt_ack    = 1'b0;
        #2 rst = 1'b0;
        #1 check("reset_outputs",
                 128'({pkt_valid, pkt_len, err_chk, err_len, err_to, overrun}), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish by 900000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           skip;
        int unsigned  len;
        int           kind;
        logic [127:0] pl;

        rst = 1'b1; data_ready = 1'b0; data_in = 8'h00; pkt_ack = 1'b0;
        #1 rst = 1'b0;
        #2 check("reset_outputs",
                 128'({pkt_valid, pkt_len, err_chk, err_len, err_to, overrun}), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        pl = {104'h0, 8'h33, 8'h22, 8'h11};
        frame_ok(3, pl, 8'h00, 1'b0, 0);
        hold_phase(0, skip);
        frame_ok(3, pl, 8'h07, 1'b0, 0);
        frame_ok(3, pl, 8'h00, 1'b0, 0);
        hold_phase(1, skip);
        frame_ok(4, rand_payload(), 8'h00, 1'b0, 0);
        hold_phase(2, skip);
        frame_ok(2, rand_payload(), 8'h00, skip, 0);
        hold_phase(0, skip);
        frame_badlen(8'h00, 1'b0);
        frame_badlen(8'h11, 1'b0);
        frame_timeout(2, {120'h0, 8'hAA}, 2, 1'b0);
        frame_ok(1, {120'h0, 8'hA5}, 8'h00, 1'b0, 0);
        hold_phase(0, skip);
        frame_ok(2, rand_payload(), 8'h00, 1'b0, 2);
        hold_phase(0, skip);
        frame_ok(16, rand_payload(), 8'h00, 1'b0, 0);
        hold_phase(0, skip);

        send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1);
        reset_now();
        frame_ok(3, pl, 8'h00, 1'b0, 0);
        hold_phase(3, skip);
        if (!skip) begin
            frame_ok(5, rand_payload(), 8'h00, 1'b0, 0);
            idle(2);
        end else begin
            frame_ok(5, rand_payload(), 8'h00, 1'b1, 0);
            idle(2);
        end
        reset_now();
        skip = 1'b0;

        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, MAX_LEN);
            pl   = rand_payload();
            if (kind == 9 && !skip) begin
                repeat ($urandom_range(1, 4))
                    drive(1'($urandom_range(0, 1)), non_sync(), 1'($urandom_range(0, 1)));
                kind = 0;
            end
            if (kind <= 4 || kind == 9) begin
                frame_ok(len, pl, 8'h00, skip, 1);
                hold_phase(3, skip);
            end else if (kind <= 6) begin
                frame_ok(len, pl, 8'($urandom_range(1, 255)), skip, 1);
                skip = 1'b0;
            end else if (kind == 7) begin
                frame_badlen(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)), skip);
                skip = 1'b0;
            end else begin
                frame_timeout(len, pl, $urandom_range(0, len + 1), skip);
                skip = 1'b0;
            end
        end

        idle(10);
        check("scoreboard_empty", 128'(sbq.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
